// File: rtl/param_gate_checker.sv
// Generic 74-series gate tester: sweeps every input pattern into NUM_GATES identical gates
// and compares each gate output against a run-time selected reference function.
module param_gate_checker #(
   parameter int NUM_GATES     = 4,
   parameter int NUM_IN        = 2,
   parameter int SETTLE_CYCLES = 50000000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [2:0]                    gate_type,
   input  logic [NUM_GATES-1:0]          gate_out,
   output logic [NUM_GATES*NUM_IN-1:0]   gate_in,
   output logic [NUM_GATES-1:0]          pass_vec,
   output logic [NUM_GATES-1:0]          fail_vec,
   output logic                          pass,
   output logic                          fail,
   output logic                          busy,
   output logic                          done
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PW = NUM_IN + 1;
   localparam logic [CW-1:0] CNT_LAST      = CW'(SETTLE_CYCLES - 1);
   localparam logic [PW-1:0] PAT_LAST_FULL = PW'((1 << NUM_IN) - 1);
   localparam logic [PW-1:0] PAT_LAST_UNI  = PW'(1);

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SAMPLE,
      EVAL,
      DONE
   } state_t;

   state_t                state;
   logic                  enable_d;
   logic                  enable_q;
   logic [2:0]            type_q;
   logic [PW-1:0]         pattern;
   logic [CW-1:0]         settle_cnt;
   logic [NUM_GATES-1:0]  mismatch;
   logic [NUM_GATES-1:0]  sample_miss;
   logic                  start;
   logic                  is_last;
   logic                  exp_bit;

   // NOT/BUF families have a single logical input, so every lane follows pattern bit 0.
   function automatic logic [NUM_IN-1:0] lanes(input logic [PW-1:0] pat, input logic [2:0] typ);
      if (typ[2:1] == 2'b11) begin
         lanes = {NUM_IN{pat[0]}};
      end else begin
         lanes = pat[NUM_IN-1:0];
      end
   endfunction

   function automatic logic [NUM_GATES*NUM_IN-1:0] drive(input logic [PW-1:0] pat,
                                                         input logic [2:0]    typ);
      drive = {NUM_GATES{lanes(pat, typ)}};
   endfunction

   function automatic logic ref_out(input logic [NUM_IN-1:0] v, input logic [2:0] typ);
      case (typ)
         3'd0:    ref_out = &v;
         3'd1:    ref_out = |v;
         3'd2:    ref_out = ~&v;
         3'd3:    ref_out = ~|v;
         3'd4:    ref_out = ^v;
         3'd5:    ref_out = ~^v;
         3'd6:    ref_out = ~v[0];
         default: ref_out = v[0];
      endcase
   endfunction

   assign start   = enable_d & ~enable_q;
   assign is_last = (type_q[2:1] == 2'b11) ? (pattern == PAT_LAST_UNI) : (pattern == PAT_LAST_FULL);
   assign exp_bit = ref_out(lanes(pattern, type_q), type_q);

   // Case-equality so a floating or unknown socket pin is reported as a mismatch.
   always_comb begin
      sample_miss = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         sample_miss[g] = (gate_out[g] !== exp_bit);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         enable_d   <= 1'b0;
         enable_q   <= 1'b0;
         type_q     <= '0;
         pattern    <= '0;
         settle_cnt <= '0;
         mismatch   <= '0;
         gate_in    <= '0;
         pass_vec   <= '0;
         fail_vec   <= '0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         enable_d <= enable;
         enable_q <= enable_d;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  type_q     <= gate_type;
                  pattern    <= '0;
                  settle_cnt <= '0;
                  mismatch   <= '0;
                  gate_in    <= drive('0, gate_type);
                  pass_vec   <= '0;
                  fail_vec   <= '0;
                  pass       <= 1'b0;
                  fail       <= 1'b0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  state      <= APPLY;
               end
            end
            APPLY, SAMPLE, EVAL: begin
               // Abort takes priority, including over publishing on the final sample.
               if (!enable) begin
                  state      <= IDLE;
                  pattern    <= '0;
                  settle_cnt <= '0;
                  gate_in    <= '0;
                  pass_vec   <= '0;
                  fail_vec   <= '0;
                  pass       <= 1'b0;
                  fail       <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b0;
               end else if (state == APPLY) begin
                  if (settle_cnt == CNT_LAST) begin
                     state <= SAMPLE;
                  end else begin
                     settle_cnt <= settle_cnt + CW'(1);
                  end
               end else if (state == SAMPLE) begin
                  mismatch <= mismatch | sample_miss;
                  if (is_last) begin
                     state <= EVAL;
                  end else begin
                     pattern    <= pattern + PW'(1);
                     settle_cnt <= '0;
                     gate_in    <= drive(pattern + PW'(1), type_q);
                     state      <= APPLY;
                  end
               end else begin
                  pass_vec <= ~mismatch;
                  fail_vec <= mismatch;
                  pass     <= (mismatch == '0);
                  fail     <= |mismatch;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  gate_in  <= '0;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_param_gate_checker.sv
// Self-checking bench for param_gate_checker: a simulated 74-series IC with optional stuck
// outputs sits on the socket, and a timeline model predicts every output cycle by cycle.
module tb_param_gate_checker;

   localparam int NG     = 4;
   localparam int NI     = 2;
   localparam int SC     = 4;
   localparam int PERIOD = SC + 1;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              enable = 1'b0;
   logic [2:0]        gate_type = 3'd0;
   logic [NG-1:0]     gate_out;
   logic [NG*NI-1:0]  gate_in;
   logic [NG-1:0]     pass_vec;
   logic [NG-1:0]     fail_vec;
   logic              pass;
   logic              fail;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   int            ic_type = 0;
   logic [NG-1:0] stuck_en = '0;
   logic [NG-1:0] stuck_val = '0;

   bit               m_run;
   int               m_k;
   int               m_type;
   logic [NG-1:0]    m_faults;
   logic [NG-1:0]    m_pv;
   logic [NG-1:0]    m_fv;
   logic             m_pass;
   logic             m_fail;
   logic             m_busy;
   logic             m_done;
   logic [NG*NI-1:0] m_gi;
   logic             en_s1;
   logic             en_s2;

   always #5 clk = ~clk;

   param_gate_checker #(
      .NUM_GATES(NG),
      .NUM_IN(NI),
      .SETTLE_CYCLES(SC)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .gate_type(gate_type),
      .gate_out(gate_out),
      .gate_in(gate_in),
      .pass_vec(pass_vec),
      .fail_vec(fail_vec),
      .pass(pass),
      .fail(fail),
      .busy(busy),
      .done(done)
   );

   // Truth of each gate family expressed through the count of high inputs.
   function automatic bit ic_ideal(input int t, input int v);
      int ones;
      ones = $countones(v);
      case (t)
         0:       return ones == NI;
         1:       return ones > 0;
         2:       return ones != NI;
         3:       return ones == 0;
         4:       return (ones % 2) == 1;
         5:       return (ones % 2) == 0;
         6:       return (v % 2) == 0;
         default: return (v % 2) == 1;
      endcase
   endfunction

   function automatic int num_patterns(input int t);
      return (t >= 6) ? 2 : (1 << NI);
   endfunction

   function automatic int lane_val(input int t, input int p);
      if (t >= 6) return (p != 0) ? ((1 << NI) - 1) : 0;
      return p;
   endfunction

   function automatic logic [NG*NI-1:0] gi_for(input int t, input int p);
      logic [NG*NI-1:0] r;
      r = '0;
      for (int g = 0; g < NG; g++) r = r | ((NG*NI)'(lane_val(t, p)) << (g * NI));
      return r;
   endfunction

   function automatic logic [NG-1:0] expected_faults(input int t);
      logic [NG-1:0] f;
      int v;
      bit chip;
      f = '0;
      for (int g = 0; g < NG; g++) begin
         for (int p = 0; p < num_patterns(t); p++) begin
            v = lane_val(t, p);
            chip = stuck_en[g] ? stuck_val[g] : ic_ideal(ic_type, v);
            if (chip != ic_ideal(t, v)) f[g] = 1'b1;
         end
      end
      return f;
   endfunction

   always_comb begin
      gate_out = '0;
      for (int g = 0; g < NG; g++) begin
         gate_out[g] = stuck_en[g] ? stuck_val[g] : ic_ideal(ic_type, int'(gate_in[g*NI +: NI]));
      end
   end

   // Timeline model: a run starts one edge after enable is first seen high, each pattern
   // lasts PERIOD edges, and results appear one edge after the final sample.
   always @(posedge clk or negedge reset_n) begin
      int total;
      int nk;
      if (!reset_n) begin
         m_run <= 1'b0; m_k <= 0; m_type <= 0; m_faults <= '0;
         m_pv <= '0; m_fv <= '0; m_pass <= 1'b0; m_fail <= 1'b0;
         m_busy <= 1'b0; m_done <= 1'b0; m_gi <= '0;
         en_s1 <= 1'b0; en_s2 <= 1'b0;
      end else begin
         en_s1 <= enable;
         en_s2 <= en_s1;
         total = num_patterns(m_type) * PERIOD;
         nk = m_k + 1;
         if (m_run) begin
            if (!enable) begin
               m_run <= 1'b0; m_busy <= 1'b0; m_gi <= '0;
            end else if (nk == total + 1) begin
               m_run <= 1'b0; m_busy <= 1'b0; m_gi <= '0; m_done <= 1'b1;
               m_pass <= (m_faults == '0); m_fail <= (m_faults != '0);
               m_pv <= ~m_faults; m_fv <= m_faults;
            end else begin
               m_k <= nk;
               m_gi <= gi_for(m_type, ((nk < total) ? nk : total - 1) / PERIOD);
            end
         end else if (en_s1 && !en_s2) begin
            m_run <= 1'b1; m_k <= 0; m_type <= int'(gate_type);
            m_faults <= expected_faults(int'(gate_type));
            m_pv <= '0; m_fv <= '0; m_pass <= 1'b0; m_fail <= 1'b0; m_done <= 1'b0;
            m_busy <= 1'b1; m_gi <= gi_for(int'(gate_type), 0);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("gate_in",  32'(gate_in),  32'(m_gi));
         checkOutput("busy",     32'(busy),     32'(m_busy));
         checkOutput("done",     32'(done),     32'(m_done));
         checkOutput("pass",     32'(pass),     32'(m_pass));
         checkOutput("fail",     32'(fail),     32'(m_fail));
         checkOutput("pass_vec", 32'(pass_vec), 32'(m_pv));
         checkOutput("fail_vec", 32'(fail_vec), 32'(m_fv));
      end
   end

   task automatic applyStimulus(input logic en, input logic [2:0] typ);
      @(posedge clk);
      #2;
      enable = en;
      gate_type = typ;
   endtask

   // Counts edges after the one that first samples enable high until done is seen.
   task automatic waitDone(output int n, output logic [7:0] gi1, output logic [7:0] gi6,
                           output logic done1);
      gi1 = '0; gi6 = '0; done1 = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 1000) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 1) begin gi1 = gate_in; done1 = done; end
         if (n == 6) gi6 = gate_in;
         if (done) break;
      end
      if (n >= 1000) checkOutput("wait_done_timeout", 32'(0), 32'(1));
   endtask

   task automatic waitModelIdle();
      int n;
      n = 0;
      while (m_run && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (m_run) checkOutput("run_timeout", 32'(1), 32'(0));
   endtask

   task automatic checkAllZero(input string name);
      checkOutput(name, 32'({gate_in, pass_vec, fail_vec, pass, fail, busy, done}), 32'(0));
   endtask

   initial begin
      int n;
      int t;
      logic [7:0] gi1;
      logic [7:0] gi6;
      logic done1;

      #1 reset_n = 1'b0;
      #3 checkAllZero("reset_state");
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      check_en = 1'b1;

      $display("[TB] NAND golden run");
      ic_type = 2; stuck_en = '0;
      applyStimulus(1'b1, 3'd2);
      waitDone(n, gi1, gi6, done1);
      checkOutput("nand_latency", 32'(n), 32'd22);
      checkOutput("nand_gi_p0", 32'(gi1), 32'h00);
      checkOutput("nand_gi_p1", 32'(gi6), 32'h55);
      checkOutput("nand_pass", 32'({pass, fail, pass_vec}), 32'b10_1111);
      applyStimulus(1'b0, 3'd2);

      $display("[TB] AND with gate 2 stuck high");
      ic_type = 0; stuck_en = 4'b0100; stuck_val = 4'b0100;
      applyStimulus(1'b1, 3'd0);
      waitDone(n, gi1, gi6, done1);
      checkOutput("stuck_flags", 32'({pass, fail}), 32'b01);
      checkOutput("stuck_fail_vec", 32'(fail_vec), 32'b0100);
      checkOutput("stuck_pass_vec", 32'(pass_vec), 32'b1011);
      applyStimulus(1'b0, 3'd0);

      $display("[TB] NOT mode");
      ic_type = 6; stuck_en = '0;
      applyStimulus(1'b1, 3'd6);
      waitDone(n, gi1, gi6, done1);
      checkOutput("not_latency", 32'(n), 32'd12);
      checkOutput("not_gi_p0", 32'(gi1), 32'h00);
      checkOutput("not_gi_p1", 32'(gi6), 32'hFF);
      checkOutput("not_pass", 32'(pass), 32'd1);
      applyStimulus(1'b0, 3'd6);
      stuck_en = 4'b0001; stuck_val = 4'b0000;
      applyStimulus(1'b1, 3'd6);
      waitDone(n, gi1, gi6, done1);
      checkOutput("not_stuck_fail_vec", 32'(fail_vec), 32'b0001);
      applyStimulus(1'b0, 3'd6);

      $display("[TB] Abort during pattern 2");
      ic_type = 0; stuck_en = '0;
      applyStimulus(1'b1, 3'd0);
      repeat (13) @(posedge clk);
      #2 enable = 1'b0;
      @(posedge clk);
      #1 checkAllZero("abort_outputs");
      applyStimulus(1'b1, 3'd0);
      waitDone(n, gi1, gi6, done1);
      checkOutput("abort_rerun_latency", 32'(n), 32'd22);
      checkOutput("abort_rerun_pass", 32'(pass), 32'd1);
      applyStimulus(1'b0, 3'd0);

      $display("[TB] Async reset mid-sample");
      ic_type = 4;
      applyStimulus(1'b1, 3'd4);
      repeat (6) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 checkAllZero("async_reset");
      enable = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 checkOutput("no_run_after_reset", 32'(busy), 32'd0);
      applyStimulus(1'b1, 3'd4);
      waitDone(n, gi1, gi6, done1);
      checkOutput("post_reset_pass", 32'(pass), 32'd1);

      $display("[TB] Enable held high after done, then restart");
      repeat (50) @(posedge clk);
      #1 checkOutput("held_no_restart", 32'({busy, done}), 32'b01);
      applyStimulus(1'b0, 3'd5);
      applyStimulus(1'b1, 3'd4);
      waitDone(n, gi1, gi6, done1);
      checkOutput("restart_cleared", 32'(done1), 32'd0);
      checkOutput("restart_pass", 32'(pass), 32'd1);
      applyStimulus(1'b0, 3'd4);

      $display("[TB] Randomized runs");
      for (int i = 0; i < 40; i++) begin
         t = $urandom_range(0, 7);
         ic_type = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : t;
         stuck_en = ($urandom_range(0, 1) == 1) ? NG'($urandom) : '0;
         stuck_val = NG'($urandom);
         applyStimulus(1'b1, 3'(t));
         applyStimulus(1'b1, 3'(t));
         applyStimulus(1'b1, 3'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            applyStimulus(1'b0, 3'($urandom));
         end else begin
            waitModelIdle();
            applyStimulus(1'b0, 3'($urandom));
         end
         repeat (2) @(posedge clk);
      end

      @(negedge clk);
      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/param_gate_checker.md
Name: param_gate_checker

Overview:
- Generalised logic-gate IC tester. Drives an exhaustive input pattern sweep into NUM_GATES identical gates of a DUT IC and compares each gate output against an internal reference model.
- Reports per-gate and overall pass/fail.
- Gate function is run-time selectable, so one instance covers the AND/OR/NAND/NOR/XOR/XNOR/NOT/BUF families of 74-series ICs. Sits between the top-level IC-select logic and the DUT socket pins.

Parameters:
NUM_GATES, 4, number of gates in the DUT package (1..8)
NUM_IN, 2, inputs per gate (1..4)
SETTLE_CYCLES, 50000000, clk cycles each pattern is held before sampling (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  run request; rising edge starts a run, low aborts
gate_type  input  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT, 7 BUF
gate_out  input  NUM_GATES  DUT gate outputs; bit g = gate g
gate_in  output  NUM_GATES*NUM_IN  DUT gate inputs; bits [g*NUM_IN +: NUM_IN] = gate g
pass_vec  output  NUM_GATES  per-gate pass
fail_vec  output  NUM_GATES  per-gate fail
pass  output  1  all gates passed
fail  output  1  at least one gate failed
busy  output  1  run in progress
done  output  1  results valid

Behaviour:
- Reset (async, reset_n=0): state IDLE. gate_in, pass_vec, fail_vec, pass, fail, busy and done are all 0. Pattern counter, settle counter and mismatch register are 0.
- All outputs are registered.
- Start condition: enable rising edge (registered enable_d), accepted in IDLE or DONE.
  - gate_type is captured into type_q at start and held for the whole run.
  - On start: pass/fail/pass_vec/fail_vec/done cleared, busy=1, mismatch register cleared.
- Pattern set:
  - Types 0-5: patterns 0 .. 2^NUM_IN-1.
  - Types 6-7: patterns 0..1 only. All NUM_IN lanes of each gate are driven with pattern bit 0.
  - Every gate receives the same pattern simultaneously.
- Reference model: reduction of the pattern per type_q. NOT = ~bit0, BUF = bit0.
- FSM:
  - IDLE: on start -> APPLY with pattern=0, gate_in driven, settle counter=0.
  - APPLY: settle counter increments each cycle. When it reaches SETTLE_CYCLES-1 -> SAMPLE.
  - SAMPLE (1 cycle): mismatch[g] |= (gate_out[g] !== expected). X/Z on gate_out counts as a mismatch. If this was the last pattern -> EVAL; else pattern+1, counter=0 -> APPLY.
  - EVAL (1 cycle): pass_vec=~mismatch, fail_vec=mismatch, pass=(mismatch==0), fail=|mismatch, done=1, busy=0, gate_in=0 -> DONE.
  - DONE: results held until the next start or reset.
- Per-pattern period is SETTLE_CYCLES+1 cycles.
- Latency: done rises P*(SETTLE_CYCLES+1)+2 clk edges after the edge that registers the start. P = 2^NUM_IN for types 0-5, P = 2 for types 6-7.
- pass and fail are mutually exclusive and both 0 unless done=1.
- Abort: enable=0 while in APPLY/SAMPLE/EVAL -> IDLE next edge. gate_in=0, busy=0, done=0, results stay cleared.
- Enable held high after DONE does not restart; a new 0->1 edge is required.
- Simultaneous abort and last SAMPLE: abort wins, no results published.
- gate_type changes mid-run are ignored.
- Pattern counter is width NUM_IN+1 and never wraps within a run.

Test Plan:
All tests use NUM_GATES=4, NUM_IN=2, SETTLE_CYCLES=4.
- NAND golden: type=2, model gate_out=~(a&b) per gate, pulse enable -> gate_in steps 00,01,10,11 every 5 cycles. done at edge 22 after start; pass=1, fail=0, pass_vec=4'b1111.
- Single stuck gate: type=0 AND, gate 2 output stuck at 1 -> fail=1, pass=0, fail_vec=4'b0100, pass_vec=4'b1011.
- NOT mode: type=6, gates model ~in0 -> only 2 patterns; gate_in = 8'h00 then 8'hFF. done at edge 12; pass=1. Repeat with gate 0 stuck at 0 -> fail_vec=4'b0001.
- Abort: deassert enable during pattern 2 -> next edge busy=0, gate_in=0, done=0, pass=fail=0. Re-raise enable -> fresh full run passes.
- Async reset mid-SAMPLE: assert reset_n=0 off-clock-edge -> all outputs 0 immediately, without waiting for clk. After release, no run starts until an enable rising edge.
- Restart: after DONE with enable held high for 50 cycles -> no new run. Toggle enable 0->1 with XOR type and correct DUT model -> results cleared at start, then pass=1.
